// File: rtl/i2c_req_arbiter_if.sv
// Bundle of every signal crossing the arbiter boundary: the requester side
// (req/command in, grant/done/response out) and the i2c_master command port.
//
// Handshakes:
//   requester : req is a level; the requester holds req and its command until
//               its done bit pulses for one cycle with rsp_* valid. grant is
//               high from the issue cycle through the done cycle.
//   master    : m_start is a one-cycle pulse with m_addr/m_rw/m_wdata stable
//               until completion; m_done is a one-cycle pulse with m_rdata and
//               m_nack valid in that same cycle. m_busy high blocks a new issue.
//
// slave modport  : the arbiter's view.
// master modport : the environment's view (requesters plus the i2c_master).
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*7-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rsp_rdata;
    logic                 rsp_nack;
    logic                 rsp_timeout;
    logic                 busy;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic                 m_rw;
    logic [7:0]           m_wdata;
    logic                 m_busy;
    logic                 m_done;
    logic [7:0]           m_rdata;
    logic                 m_nack;
    // Current arbiter state, for debug visibility only.
    logic [1:0]           dbg_state;

    modport slave (
        input  req, req_addr, req_rw, req_wdata,
        input  m_busy, m_done, m_rdata, m_nack,
        output grant, done, rsp_rdata, rsp_nack, rsp_timeout, busy,
        output m_start, m_addr, m_rw, m_wdata, dbg_state
    );

    modport master (
        output req, req_addr, req_rw, req_wdata,
        output m_busy, m_done, m_rdata, m_nack,
        input  grant, done, rsp_rdata, rsp_nack, rsp_timeout, busy,
        input  m_start, m_addr, m_rw, m_wdata, dbg_state
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between NUM_REQ
// requesters. The winner's command is latched, a start pulse is issued, and
// the master's completion (or a watchdog abort) is returned to the winner.
module i2c_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    i2c_req_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter reads 0 in the first WAIT cycle; the cycle in which it holds
    // TIMEOUT-2 is the one where its incremented value reaches TIMEOUT-1, so the
    // done pulse lands TIMEOUT cycles after the issue cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);
    localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  win;
    logic [CW-1:0]  cnt;

    logic [6:0]     cmd_addr;
    logic           cmd_rw;
    logic [7:0]     cmd_wdata;

    logic [7:0]     rsp_rdata_q;
    logic           rsp_nack_q;
    logic           rsp_timeout_q;

    logic           hi_valid;
    logic           lo_valid;
    logic [IW-1:0]  hi_idx;
    logic [IW-1:0]  lo_idx;
    logic           pick_valid;
    logic [IW-1:0]  pick_idx;

    logic [6:0]     sel_addr;
    logic           sel_rw;
    logic [7:0]     sel_wdata;

    logic           take;
    logic           wait_expired;

    logic [NUM_REQ-1:0] grant_v;
    logic [NUM_REQ-1:0] done_v;

    // Round-robin pick: lowest requesting index above ptr, else lowest at or below ptr.
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i]) begin
                if (IW'(i) > ptr) begin
                    if (!hi_valid) begin
                        hi_valid = 1'b1;
                        hi_idx   = IW'(i);
                    end
                end else if (!lo_valid) begin
                    lo_valid = 1'b1;
                    lo_idx   = IW'(i);
                end
            end
        end
        pick_valid = hi_valid | lo_valid;
        pick_idx   = hi_valid ? hi_idx : lo_idx;
    end

    // Select the picked requester's command fields out of the packed buses.
    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = bus.req_addr[7*i +: 7];
                sel_rw    = bus.req_rw[i];
                sel_wdata = bus.req_wdata[8*i +: 8];
            end
        end
    end

    // A new transaction is only taken while the master reports idle.
    assign take         = (state == ST_IDLE) && pick_valid && !bus.m_busy;
    assign wait_expired = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; m_done takes precedence over the watchdog in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (take) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.m_done || wait_expired) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner and its command when leaving IDLE; advance ptr on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= PTR_INIT;
            win       <= '0;
            cmd_addr  <= '0;
            cmd_rw    <= 1'b0;
            cmd_wdata <= '0;
        end else begin
            if (take) begin
                win       <= pick_idx;
                cmd_addr  <= sel_addr;
                cmd_rw    <= sel_rw;
                cmd_wdata <= sel_wdata;
            end
            if (state == ST_DONE) begin
                ptr <= win;
            end
        end
    end

    // Watchdog counter: cleared on issue, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_ISSUE) begin
            cnt <= '0;
        end else if (state == ST_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Response capture at the end of WAIT; held unchanged at all other times.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q   <= '0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (bus.m_done) begin
                rsp_rdata_q   <= bus.m_rdata;
                rsp_nack_q    <= bus.m_nack;
                rsp_timeout_q <= 1'b0;
            end else if (wait_expired) begin
                rsp_rdata_q   <= '0;
                rsp_nack_q    <= 1'b0;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    // One-hot grant from ISSUE through DONE, one-hot done in DONE only.
    always_comb begin
        grant_v = '0;
        done_v  = '0;
        if (state != ST_IDLE) begin
            grant_v[win] = 1'b1;
        end
        if (state == ST_DONE) begin
            done_v[win] = 1'b1;
        end
    end

    assign bus.grant       = grant_v;
    assign bus.done        = done_v;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_nack    = rsp_nack_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.m_start     = (state == ST_ISSUE);
    assign bus.m_addr      = cmd_addr;
    assign bus.m_rw        = cmd_rw;
    assign bus.m_wdata     = cmd_wdata;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios plus randomized transactions,
// checked against a transaction-level model of the arbitration and timing rules.
module tb_i2c_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 24;
    localparam int RW      = NUM_REQ + 10;

    logic clk;
    logic reset;

    i2c_req_arbiter_if #(.NUM_REQ(NUM_REQ)) ifc ();

    i2c_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected response words: {done one-hot, timeout, nack, rdata}.
    logic [RW-1:0] exp_q[$];

    logic [6:0]         addr_a  [NUM_REQ];
    logic               rw_a    [NUM_REQ];
    logic [7:0]         wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0] req_v;
    int                 last;

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Structural invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("grant_onehot0", 32'($onehot0(ifc.grant)), 32'd1);
            check("done_onehot0", 32'($onehot0(ifc.done)), 32'd1);
            check("done_within_grant", 32'(ifc.done & ~ifc.grant), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            ifc.req_addr[7*i +: 7]  = addr_a[i];
            ifc.req_rw[i]           = rw_a[i];
            ifc.req_wdata[8*i +: 8] = wdata_a[i];
        end
        ifc.req = req_v;
    endtask

    task automatic set_cmd(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        addr_a[idx]  = a;
        rw_a[idx]    = rw;
        wdata_a[idx] = wd;
    endtask

    // Next requester after 'after' in circular order that is asserting req.
    function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int after);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(after + k) % NUM_REQ]) return (after + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // One complete transaction, starting from a visible IDLE cycle with req_v applied.
    // delay = cycle after issue in which the master pulses m_done; 0 = never.
    task automatic run_txn(input int delay, input logic nack_v, input logic [7:0] rdata_v,
                           input bit early_drop, input bit keep_req);
        int                 win;
        int                 done_at;
        logic               to;
        logic [NUM_REQ-1:0] oh;
        logic [RW-1:0]      e;
        logic [RW-1:0]      got;

        win = model_pick(req_v, last);
        check("model_has_request", 32'(win >= 0), 32'd1);
        if (win < 0) return;

        oh      = NUM_REQ'(1) << win;
        to      = !(delay >= 1 && delay <= TIMEOUT - 1);
        done_at = to ? TIMEOUT : delay + 1;
        e       = {oh, to, to ? 1'b0 : nack_v, to ? 8'h00 : rdata_v};
        exp_q.push_back(e);

        step();
        check("m_start_issue", 32'(ifc.m_start), 32'd1);
        check("grant_issue", 32'(ifc.grant), 32'(oh));
        check("busy_issue", 32'(ifc.busy), 32'd1);
        check("done_issue", 32'(ifc.done), 32'd0);
        check("m_addr", 32'(ifc.m_addr), 32'(addr_a[win]));
        check("m_rw", 32'(ifc.m_rw), 32'(rw_a[win]));
        check("m_wdata", 32'(ifc.m_wdata), 32'(wdata_a[win]));

        for (int k = 1; k <= done_at; k++) begin
            step();
            ifc.m_done  = (k == delay);
            ifc.m_rdata = (k == delay) ? rdata_v : 8'($urandom);
            ifc.m_nack  = (k == delay) ? nack_v : 1'($urandom);
            check("grant_hold", 32'(ifc.grant), 32'(oh));
            check("m_start_low", 32'(ifc.m_start), 32'd0);
            check("m_addr_hold", 32'(ifc.m_addr), 32'(addr_a[win]));
            check("m_wdata_hold", 32'(ifc.m_wdata), 32'(wdata_a[win]));
            if (k < done_at) begin
                check("done_early", 32'(ifc.done), 32'd0);
            end else begin
                got = {ifc.done, ifc.rsp_timeout, ifc.rsp_nack, ifc.rsp_rdata};
                check("response", 32'(got), 32'(exp_q.pop_front()));
            end
            if (early_drop && k == 2) begin
                req_v[win] = 1'b0;
                drive_inputs();
            end
        end
        ifc.m_done = 1'b0;
        last = win;
        if (!keep_req) req_v[win] = 1'b0;
        drive_inputs();

        step();
        check("grant_idle", 32'(ifc.grant), 32'd0);
        check("busy_idle", 32'(ifc.busy), 32'd0);
        check("done_idle", 32'(ifc.done), 32'd0);
        check("m_start_idle", 32'(ifc.m_start), 32'd0);
        check("rsp_hold", 32'({ifc.rsp_timeout, ifc.rsp_nack, ifc.rsp_rdata}), 32'(e[9:0]));
    endtask

    initial begin
        int d;
        int r;
        reset       = 1'b1;
        req_v       = '0;
        ifc.m_busy  = 1'b0;
        ifc.m_done  = 1'b0;
        ifc.m_rdata = '0;
        ifc.m_nack  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 7'h00, 1'b0, 8'h00);
        drive_inputs();
        last = NUM_REQ - 1;

        // Reset state.
        step();
        step();
        check("rst_grant", 32'(ifc.grant), 32'd0);
        check("rst_done", 32'(ifc.done), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_m_start", 32'(ifc.m_start), 32'd0);
        check("rst_cmd", 32'({ifc.m_addr, ifc.m_rw, ifc.m_wdata}), 32'd0);
        check("rst_rsp", 32'({ifc.rsp_rdata, ifc.rsp_nack, ifc.rsp_timeout}), 32'd0);
        reset = 1'b0;

        // Single write, master completes 20 cycles after start.
        set_cmd(0, 7'h50, 1'b0, 8'hA5);
        req_v = 4'b0001;
        drive_inputs();
        run_txn(20, 1'b0, 8'h77, 1'b0, 1'b0);

        // Round-robin with all requests held high.
        for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 7'($urandom), 1'($urandom), 8'($urandom));
        req_v = 4'b1111;
        drive_inputs();
        for (int t = 0; t < 5; t++) begin
            run_txn($urandom_range(1, 8), 1'($urandom), 8'($urandom), 1'b0, 1'b1);
        end
        req_v = '0;
        drive_inputs();

        // Read with NACK from requester 2.
        set_cmd(2, 7'h1D, 1'b1, 8'h00);
        req_v = 4'b0100;
        drive_inputs();
        run_txn(7, 1'b1, 8'h3C, 1'b0, 1'b0);

        // Watchdog abort, then the other pending requester is served.
        set_cmd(0, 7'h21, 1'b0, 8'h5A);
        set_cmd(1, 7'h22, 1'b1, 8'h00);
        req_v = 4'b0011;
        drive_inputs();
        run_txn(0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_txn(3, 1'b0, 8'h9E, 1'b0, 1'b0);

        // m_done in the final watchdog cycle wins over the abort.
        set_cmd(3, 7'h33, 1'b1, 8'h00);
        req_v = 4'b1000;
        drive_inputs();
        run_txn(TIMEOUT - 1, 1'b0, 8'hC3, 1'b0, 1'b0);

        // m_busy blocks issue; a stray m_done in IDLE is ignored.
        ifc.m_busy = 1'b1;
        set_cmd(0, 7'h44, 1'b0, 8'h12);
        req_v = 4'b0001;
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            step();
            ifc.m_done = (c == 2);
            check("blocked_m_start", 32'(ifc.m_start), 32'd0);
            check("blocked_busy", 32'(ifc.busy), 32'd0);
            check("blocked_done", 32'(ifc.done), 32'd0);
        end
        ifc.m_done = 1'b0;
        ifc.m_busy = 1'b0;
        run_txn(4, 1'b0, 8'h01, 1'b0, 1'b0);

        // Reset in the middle of WAIT aborts without a done pulse.
        set_cmd(2, 7'h55, 1'b0, 8'hEE);
        req_v = 4'b0100;
        drive_inputs();
        step();
        check("abort_m_start", 32'(ifc.m_start), 32'd1);
        check("abort_grant", 32'(ifc.grant), 32'b0100);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("abort_grant_clr", 32'(ifc.grant), 32'd0);
        check("abort_busy_clr", 32'(ifc.busy), 32'd0);
        check("abort_no_done", 32'(ifc.done), 32'd0);
        check("abort_m_addr", 32'(ifc.m_addr), 32'd0);
        reset = 1'b0;
        last  = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 7'($urandom), 1'($urandom), 8'($urandom));
        req_v = 4'b1111;
        drive_inputs();
        run_txn(2, 1'b0, 8'h66, 1'b0, 1'b0);
        req_v = '0;
        drive_inputs();

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_v[i] && $urandom_range(0, 1) == 1) begin
                    set_cmd(i, 7'($urandom), 1'($urandom), 8'($urandom));
                    req_v[i] = 1'b1;
                end
            end
            if (req_v == '0) begin
                r = $urandom_range(0, NUM_REQ - 1);
                set_cmd(r, 7'($urandom), 1'($urandom), 8'($urandom));
                req_v[r] = 1'b1;
            end
            drive_inputs();
            r = $urandom_range(0, 9);
            if (r == 0)      d = 0;
            else if (r == 1) d = 1;
            else if (r == 2) d = TIMEOUT - 1;
            else             d = $urandom_range(1, TIMEOUT - 1);
            run_txn(d, 1'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        req_v = '0;
        drive_inputs();
        step();
        step();
        check("final_idle_busy", 32'(ifc.busy), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares one i2c_master command port between NUM_REQ requesters, e.g. a sensor poller, a config loader and a debug port.
- Arbitration is round-robin. The block latches the winner's command and pulses the master's start.
- It waits for master completion, or a watchdog timeout, then returns read data and status to the granted requester.
- Sits directly in front of i2c_master inside the I2C subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, clk cycles allowed in WAIT before the transaction is aborted (>= 2).

Ports:
- clk  in  1  system clock; also the I2C bit clock source.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  NUM_REQ*7  packed 7-bit slave addresses; slot i at [7i+6:7i].
- req_rw  in  NUM_REQ  per-requester direction, 1 = read.
- req_wdata  in  NUM_REQ*8  packed write bytes; slot i at [8i+7:8i].
- grant  out  NUM_REQ  one-hot, high from ISSUE until DONE inclusive.
- done  out  NUM_REQ  one-hot single-cycle completion pulse.
- rsp_rdata  out  8  read byte, valid while done != 0.
- rsp_nack  out  1  slave NACK flag, valid while done != 0.
- rsp_timeout  out  1  watchdog abort flag, valid while done != 0.
- busy  out  1  high in any state except IDLE.
- m_start  out  1  start pulse to master.
- m_addr  out  7  address to master.
- m_rw  out  1  direction to master.
- m_wdata  out  8  write byte to master.
- m_busy  in  1  master not idle.
- m_done  in  1  master completion pulse.
- m_rdata  in  8  master read byte, valid with m_done.
- m_nack  in  1  master NACK flag, valid with m_done.

Behaviour:
Reset (synchronous, active-high, sampled on rising clk):
- Forces state IDLE; grant, done, m_start, busy, rsp_* all 0.
- m_addr/m_rw/m_wdata reset to 0.
- Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Timeout counter = 0.
- Reset in any state aborts silently: no done pulse is emitted.

State machine, states IDLE, ISSUE, WAIT, DONE:

IDLE:
- If |req and !m_busy, select the winner: the first asserted req scanning idx = ptr+1, ptr+2, ... modulo NUM_REQ.
- Latch winner index and its addr/rw/wdata into command registers, then go to ISSUE.
- If m_busy = 1, stay in IDLE regardless of req.

ISSUE (exactly 1 cycle):
- grant[win] = 1; m_start = 1; m_addr/m_rw/m_wdata driven from the latched registers.
- Clear the timeout counter and go to WAIT.

WAIT:
- grant[win] held; m_start = 0; m_addr/m_rw/m_wdata held stable.
- Counter increments each cycle.
- On m_done = 1: capture m_rdata into rsp_rdata and m_nack into rsp_nack, clear rsp_timeout, go to DONE.
- Else, when the counter reaches TIMEOUT-1: rsp_timeout = 1, rsp_nack = 0, rsp_rdata = 0, go to DONE.
- If m_done and timeout occur in the same cycle, m_done wins.

DONE (exactly 1 cycle):
- done[win] = 1 with rsp_* valid; grant[win] still 1.
- ptr <= win. Next state IDLE, with grant cleared.

Latency and throughput:
- Request to m_start: 1 cycle, i.e. req sampled in cycle n gives m_start in cycle n+1.
- m_done to done: 1 cycle.
- Minimum gap between consecutive m_start pulses: 3 cycles after m_done.

Handshake rules:
- Requester holds req and its command until it sees its done bit.
- req deasserted after grant: the transaction still completes and done still pulses.
- req held high after done: treated as a new request, arbitrated in the next IDLE.
- m_done outside WAIT is ignored.

Other:
- rsp_* hold their last values outside DONE.
- done and grant are never non-zero for more than one index.
- Counter width: $clog2(TIMEOUT+1).
- Index width: max(1, $clog2(NUM_REQ)).

Test Plan:
- Single write: req = 4'b0001, addr 0x50, rw 0, wdata 0xA5; master model returns m_done after 20 cycles with nack 0 -> m_start pulses 1 cycle after req with m_addr = 0x50, m_wdata = 0xA5; grant = 0001 for 22 cycles; done = 0001 one cycle later with rsp_nack = 0, rsp_timeout = 0.
- Round-robin: req = 4'b1111 held high after reset -> grant order 0, 1, 2, 3, 0; each grant followed by exactly one done pulse; never two grant bits set.
- Read with NACK: requester 2 reads addr 0x1D; model returns m_rdata = 0x3C, m_nack = 1 -> done = 0100, rsp_rdata = 0x3C, rsp_nack = 1.
- Timeout: TIMEOUT = 16; model never asserts m_done -> done pulses 16 cycles after ISSUE with rsp_timeout = 1, rsp_rdata = 0x00; the next pending requester is then served.
- Busy blocking and reset: m_busy = 1 with req = 0001 -> no m_start until m_busy falls, then m_start on the next cycle. Assert reset for 1 cycle mid-WAIT -> next cycle grant = 0, busy = 0, no done pulse, and requester 0 has priority again.
- Simultaneous m_done and timeout in the final timeout cycle -> rsp_timeout = 0 and rsp_rdata = m_rdata.
